// File: rtl/wire_adc_mmio_if.sv
// wire_adc_mmio_if
//   CPU memory-bus bundle for the wire-sense ADC block.
//   data : write data          (master -> slave)
//   addr : address             (master -> slave)
//   en   : write enable        (master -> slave)
//   q    : registered read data (slave -> master)
interface wire_adc_mmio_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  en;
    logic [DATA_WIDTH-1:0] q;

    modport master (output data, output addr, output en, input q);
    modport slave  (input data, input addr, input en, output q);
endinterface

// File: rtl/wire_adc_mmio.sv
// wire_adc_mmio
//   Scans NUM_CH channels of an 8-channel 12-bit SPI ADC round-robin,
//   classifies each sample as wire connected/cut with debounce, keeps sticky
//   change flags and exposes everything on the CPU bus (1-cycle read).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : data/addr/en in, q out (registered read data)
//   ADC_CONVST/SCK/SDI out, ADC_SDO in : converter serial interface
//   wire_state      : debounced per-channel state, 1 = connected
//   irq             : OR of all change flags (registered)
module wire_adc_mmio #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_CH     = 6,
    parameter int SCK_HALF   = 4,
    parameter int CONV_WAIT  = 80,
    parameter int THRESH     = 2048,
    parameter int STABLE_CNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    wire_adc_mmio_if.slave    bus,
    output logic              ADC_CONVST,
    output logic              ADC_SCK,
    output logic              ADC_SDI,
    input  logic              ADC_SDO,
    output logic [NUM_CH-1:0] wire_state,
    output logic              irq
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_START, S_WAIT, S_SHIFT, S_STORE} state_t;

    state_t                  state_q;
    logic [15:0]             cnt_q;
    logic [3:0]              bit_q;
    logic [5:0]              cfg_q;      // config word, shifted out MSB first
    logic [11:0]             sh_q;       // incoming result
    logic                    convst_q, sck_q, sdi_q;
    logic [CHW-1:0]          cfg_ch_q, prev_ch_q;
    logic                    prev_vld_q; // prev_ch_q names a real conversion
    logic [11:0]             sample_q [NUM_CH];
    logic [3:0]              dbc_q    [NUM_CH];
    logic [NUM_CH-1:0]       valid_q, ws_q, change_q, change_d;
    logic [15:0]             frame_q;
    logic                    irq_q;
    logic [DATA_WIDTH-1:0]   q_q, q_d;

    logic [2:0]              n3;
    logic [5:0]              cfg_word;
    logic                    cls;
    logic [NUM_CH-1:0]       hit, tog, clr;
    logic [15:0]             rd16;

    // Converter config: single-ended, unipolar, no sleep.
    assign n3       = 3'(cfg_ch_q);
    assign cfg_word = {1'b1, n3[0], n3[2], n3[1], 1'b1, 1'b0};
    assign cls      = (sh_q >= 12'(THRESH));

    always_comb begin
        hit = '0;
        tog = '0;
        clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (state_q == S_STORE) && prev_vld_q && (prev_ch_q == CHW'(i));
            tog[i] = hit[i] && (cls != ws_q[i]) && (dbc_q[i] == 4'(STABLE_CNT - 1));
        end
        if (bus.en && bus.addr[11] && (bus.addr[1:0] == 2'd1))
            clr = bus.data[NUM_CH-1:0];
        // A set from STORE beats a same-cycle W1C of the same bit.
        change_d = (change_q & ~clr) | tog;
    end

    always_comb begin
        rd16 = 16'hAAAA;
        if (!bus.addr[11]) begin
            for (int i = 0; i < NUM_CH; i++)
                if (bus.addr[10:8] == 3'(i))
                    rd16 = {valid_q[i], 3'b000, sample_q[i]};
        end else begin
            case (bus.addr[1:0])
                2'd0:    rd16 = 16'(ws_q);
                2'd1:    rd16 = 16'(change_q);
                2'd2:    rd16 = frame_q;
                default: rd16 = {4'(NUM_CH), 12'h0A2};
            endcase
        end
        q_d = DATA_WIDTH'(rd16);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_START;
            cnt_q      <= '0;
            bit_q      <= '0;
            cfg_q      <= '0;
            sh_q       <= '0;
            convst_q   <= 1'b0;
            sck_q      <= 1'b0;
            sdi_q      <= 1'b0;
            cfg_ch_q   <= '0;
            prev_ch_q  <= '0;
            prev_vld_q <= 1'b0;
            valid_q    <= '0;
            ws_q       <= '0;
            change_q   <= '0;
            frame_q    <= '0;
            irq_q      <= 1'b0;
            q_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sample_q[i] <= '0;
                dbc_q[i]    <= '0;
            end
        end else begin
            change_q <= change_d;
            irq_q    <= |change_q;
            q_q      <= q_d;
            case (state_q)
                S_START: begin
                    // CONVST is registered: high for cnt 1..2 of this state.
                    if (cnt_q == 16'd2) begin
                        convst_q <= 1'b0;
                        cnt_q    <= '0;
                        cfg_q    <= cfg_word;
                        sdi_q    <= cfg_word[5];
                        state_q  <= S_WAIT;
                    end else begin
                        convst_q <= 1'b1;
                        cnt_q    <= cnt_q + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 16'(CONV_WAIT - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == 16'(SCK_HALF - 1)) begin
                        sck_q <= 1'b1;
                        sh_q  <= {sh_q[10:0], ADC_SDO};
                        cnt_q <= cnt_q + 16'd1;
                    end else if (cnt_q == 16'(2 * SCK_HALF - 1)) begin
                        // Falling SCK: next config bit, zeros once the word is out.
                        sck_q <= 1'b0;
                        cnt_q <= '0;
                        sdi_q <= cfg_q[4];
                        cfg_q <= {cfg_q[4:0], 1'b0};
                        if (bit_q == 4'd11) state_q <= S_STORE;
                        else                bit_q   <= bit_q + 4'd1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin // S_STORE
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (hit[i]) begin
                            sample_q[i] <= sh_q;
                            valid_q[i]  <= 1'b1;
                            if (cls == ws_q[i] || tog[i]) dbc_q[i] <= '0;
                            else                          dbc_q[i] <= dbc_q[i] + 4'd1;
                            ws_q[i] <= ws_q[i] ^ tog[i];
                        end
                    end
                    if (prev_vld_q) frame_q <= frame_q + 16'd1;
                    // This frame's config becomes the owner of the next result.
                    prev_ch_q  <= cfg_ch_q;
                    prev_vld_q <= 1'b1;
                    cfg_ch_q   <= (cfg_ch_q == CHW'(NUM_CH - 1)) ? '0 : cfg_ch_q + 1'b1;
                    cnt_q      <= '0;
                    state_q    <= S_START;
                end
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bus.addr[ADDR_WIDTH-1:12], bus.addr[7:2], bus.data[DATA_WIDTH-1:NUM_CH]};

    assign ADC_CONVST = convst_q;
    assign ADC_SCK    = sck_q;
    assign ADC_SDI    = sdi_q;
    assign wire_state = ws_q;
    assign irq        = irq_q;
    assign bus.q      = q_q;
endmodule

// File: tb/tb_wire_adc_mmio.sv
module tb_wire_adc_mmio;
    localparam int SCK_HALF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wire_adc_mmio_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus  ();
    wire_adc_mmio_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus1 ();

    logic       convst, sck, sdi, sdo, irq;
    logic [5:0] ws;
    logic       convst1, sck1, sdi1, irq1;
    logic [0:0] ws1;

    wire_adc_mmio #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_CH(6), .SCK_HALF(SCK_HALF),
                    .CONV_WAIT(80), .THRESH(2048), .STABLE_CNT(3)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .ADC_CONVST(convst), .ADC_SCK(sck), .ADC_SDI(sdi), .ADC_SDO(sdo),
        .wire_state(ws), .irq(irq));

    // Single-channel build, converter always returns full scale.
    wire_adc_mmio #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_CH(1), .SCK_HALF(SCK_HALF),
                    .CONV_WAIT(80), .THRESH(2048), .STABLE_CNT(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .ADC_CONVST(convst1), .ADC_SCK(sck1), .ADC_SDI(sdi1), .ADC_SDO(1'b1),
        .wire_state(ws1), .irq(irq1));

    // ---------------- ADC model + frame monitor ----------------
    int         chval [8];
    int         seq2  [9];
    bit         seq_mode = 0;

    int         rises = 0, pend_ch = 0, ch2_idx = 0, ch2_done = 0;
    bit         cur_seq = 0;
    logic       conv_prev = 0, sck_prev = 0;
    logic [11:0] adc_sh = '0;
    logic [5:0] cap = '0, last_cfg = '0;
    int         sck_rises = 0, hi_w = 0, conv_hi = 0, last_rises = 0, last_conv_hi = 0;
    bit         hi_bad = 0, last_bad = 0;

    assign sdo = adc_sh[11];

    always @(posedge clk) begin
        conv_prev <= convst;
        sck_prev  <= sck;
        if (convst) conv_hi <= conv_hi + 1;
        if (sck)    hi_w    <= hi_w + 1;
        if (!convst && conv_prev) begin
            // conversion result belongs to the channel configured last frame
            last_conv_hi <= conv_hi;
            conv_hi      <= 0;
            if (seq_mode && pend_ch == 2) begin
                adc_sh  <= 12'(seq2[(ch2_idx > 8) ? 8 : ch2_idx]);
                ch2_idx <= ch2_idx + 1;
                cur_seq <= 1;
            end else begin
                adc_sh  <= 12'(chval[pend_ch]);
                cur_seq <= 0;
            end
        end else if (!sck && sck_prev) begin
            adc_sh <= {adc_sh[10:0], 1'b0};
        end
        if (sck && !sck_prev) begin
            if (sck_rises < 6) cap <= {cap[4:0], sdi};
            sck_rises <= sck_rises + 1;
        end
        if (!sck && sck_prev) begin
            if (hi_w != SCK_HALF) hi_bad <= 1;
            hi_w <= 0;
        end
        if (convst && !conv_prev) begin
            rises      <= rises + 1;
            last_cfg   <= cap;
            last_rises <= sck_rises;
            last_bad   <= hi_bad;
            sck_rises  <= 0;
            hi_bad     <= 0;
            pend_ch    <= int'({cap[3], cap[2], cap[4]});
            if (cur_seq) ch2_done <= ch2_done + 1;
            cur_seq    <= 0;
        end
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
        bus.addr = a;
        @(negedge clk);
        chk(tag, bus.q, exp);
    endtask

    task automatic rd1(input logic [15:0] a, input logic [15:0] exp, input string tag);
        bus1.addr = a;
        @(negedge clk);
        chk(tag, bus1.q, exp);
    endtask

    task automatic wait_rises(input int target);
        int t = 0;
        while (rises < target && t < 20000) begin @(negedge clk); t++; end
        chk("frame_wait", 32'(rises >= target), 32'd1);
    endtask

    task automatic wait_ch2(input int target);
        int t = 0;
        while (ch2_done < target && t < 20000) begin @(negedge clk); t++; end
        chk("ch2_wait", 32'(ch2_done >= target), 32'd1);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.addr = a; bus.data = d; bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0; bus.data = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base, t, f;
        logic p;
        for (int i = 0; i < 8; i++) chval[i] = 32'h100 + i;
        seq2 = '{4000, 4000, 100, 4000, 4000, 4000, 100, 100, 100};
        bus.en = 0;  bus.data = '0;  bus.addr = '0;
        bus1.en = 0; bus1.data = '0; bus1.addr = '0;

        repeat (3) @(negedge clk);
        chk("reset_outs", {convst, sck, sdi, irq, ws, bus.q}, 32'd0);
        chk("reset_outs1", {convst1, sck1, sdi1, irq1, ws1, bus1.q}, 32'd0);
        rst = 1'b0;
        base = rises;

        // frame 6 configures channel 5
        wait_rises(base + 7);
        chk("sdi_cfg5", last_cfg, 6'b111010);
        chk("sck_rises", last_rises, 12);
        chk("sck_high_w", last_bad, 0);
        chk("convst_hi", last_conv_hi, 2);

        // seven STOREs done, first discarded
        wait_rises(base + 8);
        rd(16'h0300, 16'h8103, "ch3");
        rd(16'h0000, 16'h8100, "ch0");
        rd(16'h0500, 16'h8105, "ch5");
        rd(16'h0600, 16'hAAAA, "ch6_absent");
        rd(16'h0802, 16'd6,    "frame_cnt");
        rd(16'h0803, 16'h60A2, "id");
        rd(16'h0800, 16'h0000, "ws_init");
        wr(16'h0300, 16'hFFFF);
        rd(16'h0300, 16'h8103, "sample_ro");

        // debounce on channel 2
        seq_mode = 1;
        wait_ch2(3);
        chk("ws2_glitch", ws[2], 1'b0);
        rd(16'h0200, 16'h8064, "ch2_100");
        wait_ch2(5);
        chk("ws2_two", ws[2], 1'b0);
        wait_ch2(6);
        chk("ws2_three", ws, 6'b000100);
        chk("irq_set", irq, 1'b1);
        rd(16'h0801, 16'h0004, "change_set");
        rd(16'h0800, 16'h0004, "ws_reg");

        // W1C on the very STORE that sets change[2] again
        t = 0;
        while (ch2_idx < 9 && t < 20000) begin @(negedge clk); t++; end
        chk("ch2_idx_wait", 32'(ch2_idx >= 9), 32'd1);
        p = sck; f = 0; t = 0;
        while (f < 12 && t < 2000) begin
            @(negedge clk); t++;
            if (p && !sck) f++;
            p = sck;
        end
        chk("sck_falls", f, 12);
        wr(16'h0801, 16'h0004);
        chk("irq_hold", irq, 1'b1);
        chk("ws2_back", ws[2], 1'b0);
        rd(16'h0801, 16'h0004, "set_wins");
        wr(16'h0801, 16'h0004);
        chk("irq_lag", irq, 1'b1);
        @(negedge clk);
        chk("irq_clr", irq, 1'b0);
        rd(16'h0801, 16'h0000, "change_clr");

        // reset during SHIFT of frame 4
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        base = rises;
        wait_rises(base + 4);
        t = 0;
        while (!sck && t < 2000) begin @(negedge clk); t++; end
        chk("in_shift", sck, 1'b1);
        rd(16'h0803, 16'h60A2, "id_pre");
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outs", {convst, sck, sdi, irq, ws, bus.q}, 32'd0);
        rst = 1'b0;
        base = rises;
        wait_rises(base + 2);
        rd(16'h0000, 16'h0000, "discard_ch0");
        rd(16'h0802, 16'd0,    "discard_cnt");
        rd1(16'h0000, 16'h0000, "n1_discard");
        wait_rises(base + 3);
        rd(16'h0000, 16'h8100, "ch0_after");
        rd(16'h0802, 16'd1,    "cnt_after");
        rd1(16'h0000, 16'h8FFF, "n1_ch0");
        rd1(16'h0100, 16'hAAAA, "n1_ch1_absent");
        rd1(16'h0802, 16'd1,    "n1_cnt");
        rd1(16'h0803, 16'h10A2, "n1_id");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
